run_ctrl: RTL

Run-control and interrupt sequencer for the pico core. It sits beside the instruction decoder and consumes its `halt_core`/`wfi_core` requests. It also latches, masks and prioritises external interrupt lines and handles debug run/step requests. From these it produces the per-cycle commit enable for the PC and register file and the interrupt-take pulse that drives the PC into a subroutine-style vector call.

---
 rtl/run_ctrl_pkg.sv | 13 +
 rtl/run_ctrl_irq_prio.sv | 23 ++
 rtl/run_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared run-control types for the pico core.
package pico;

  // Run state encoding; the values are visible on state_o.
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_RUN   = 3'd1,
    S_WFI   = 3'd2,
    S_HALT  = 3'd3,
    S_STEP  = 3'd4
  } runState;

endpackage

// File: rtl/run_ctrl_irq_prio.sv
// Fixed-priority find-first-one encoder: the lowest set request index wins.
module irq_prio #(
  parameter int N_IRQ = 4,
  parameter int IW    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic             valid_o,
  output logic [IW-1:0]    id_o
);

  // Scan from the top down so the lowest set index is the last write and wins.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run-control and interrupt sequencer: commit enable, interrupt take,
// halt/step/wait-for-interrupt handling for the pico core.
module run_ctrl
  import pico::*;
#(
  parameter int N_IRQ = 4,
  parameter int IW    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             halt_core_i,
  input  logic             wfi_core_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             isr_ret_i,
  input  logic             dbg_run_i,
  input  logic             dbg_step_i,
  output logic             pc_en_o,
  output logic             int_take_o,
  output logic [IW-1:0]    int_id_o,
  output logic             in_isr_o,
  output logic [2:0]       state_o
);

  runState          r_state;
  runState          w_next;
  logic [N_IRQ-1:0] r_pend;
  logic             r_in_isr;
  logic             r_wake_q;

  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_clr;
  logic             w_valid;
  logic [IW-1:0]    w_id;
  logic             w_take;
  logic             w_pc_en;
  logic             w_wake_d;

  assign w_elig = r_pend & irq_mask_i;

  irq_prio #(
    .N_IRQ (N_IRQ),
    .IW    (IW)
  ) u_prio (
    .req_i   (w_elig),
    .valid_o (w_valid),
    .id_o    (w_id)
  );

  // No nesting: a take needs RUN and no active service routine.
  assign w_take   = (r_state == S_RUN) && w_valid && !r_in_isr;
  // wake_q marks the single cycle right after leaving WFI.
  assign w_wake_d = (r_state == S_WFI) && w_valid;

  // Clear mask for the pend register: one-hot of the id being taken.
  always_comb begin
    w_clr = '0;
    if (w_take) w_clr[w_id] = 1'b1;
  end

  // Next-state and commit-enable decode.
  always_comb begin
    w_next  = r_state;
    w_pc_en = 1'b0;
    case (r_state)
      S_RESET: w_next = S_RUN;
      S_RUN: begin
        if (w_take) begin
          w_pc_en = 1'b0;
        end else if (halt_core_i && !r_wake_q) begin
          w_next = S_HALT;
        end else if (wfi_core_i && !r_wake_q) begin
          w_next = S_WFI;
        end else begin
          w_pc_en = 1'b1;
        end
      end
      S_WFI: begin
        if (w_valid) w_next = S_RUN;
      end
      S_HALT: begin
        if (dbg_step_i)     w_next = S_STEP;
        else if (dbg_run_i) w_next = S_RUN;
      end
      S_STEP: begin
        w_pc_en = 1'b1;
        w_next  = S_HALT;
      end
      default: w_next = S_RESET;
    endcase
  end

  // State, pending lines, ISR flag and wake marker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_RESET;
      r_pend   <= '0;
      r_in_isr <= 1'b0;
      r_wake_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pend   <= (r_pend | irq_i) & ~w_clr;
      r_wake_q <= w_wake_d;
      if (w_take)
        r_in_isr <= 1'b1;
      else if (w_pc_en && isr_ret_i && r_in_isr)
        r_in_isr <= 1'b0;
    end
  end

  assign pc_en_o    = w_pc_en;
  assign int_take_o = w_take;
  assign int_id_o   = w_take ? w_id : '0;
  assign in_isr_o   = r_in_isr;
  assign state_o    = r_state;

endmodule
